// File: rtl/my_struct_s.sv
// my_struct_s: shared packet-path types and constants
package my_struct_s;
    localparam int PKT_NUM = 1024;
    localparam int PKT_AWIDTH = $clog2(PKT_NUM);
    localparam int PKTBUF_AWIDTH = PKT_AWIDTH + 5;
    localparam logic [1:0] PKT_ETH = 2'd1;
    localparam logic [1:0] PKT_DROP = 2'd2;
    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } flit_t;
    typedef struct packed {
        logic [PKT_AWIDTH-1:0] pktID;
        logic [4:0]            flits;
        logic [15:0]           len;
        logic [1:0]            pkt_flags;
    } metadata_t;
endpackage

// File: rtl/pkt_buffer_writer_len.sv
// pkt_len_calc: registered byte length from flit count and trailing empty bytes
module pkt_len_calc (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [4:0]  flits_i,
    input  logic [5:0]  empty_i,
    output logic [15:0] len_o
);
    logic [15:0] len_q, len_d;
    // full flits carry 64 bytes, the last one 64 minus its empty bytes
    always_comb len_d = load_i ? ((({11'd0, flits_i} - 16'd1) << 6) + 16'd64 - {10'd0, empty_i}) : len_q;
    // hold the length of the most recently completed packet
    always_ff @(posedge clk) len_q <= rst ? '0 : len_d;
    assign len_o = len_q;
endmodule

// File: rtl/pkt_buffer_writer.sv
// pkt_buffer_writer: writes ingress flits into the packet buffer and emits one descriptor per packet
module pkt_buffer_writer
    import my_struct_s::*;
#(
    parameter int MAX_FLITS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_pkt_valid,
    input  logic                     in_pkt_sop,
    input  logic                     in_pkt_eop,
    input  logic [511:0]             in_pkt_data,
    input  logic [5:0]               in_pkt_empty,
    output logic                     in_pkt_ready,
    input  logic [PKT_AWIDTH-1:0]    emptylist_out_data,
    input  logic                     emptylist_out_valid,
    output logic                     emptylist_out_ready,
    output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
    output logic                     pkt_buffer_write,
    output flit_t                    pkt_buffer_writedata,
    output logic                     meta_valid,
    output metadata_t                meta_data,
    input  logic                     meta_ready,
    output logic [31:0]              drop_cnt,
    output logic [31:0]              orphan_cnt
);
    typedef enum logic [2:0] {FETCH, WAIT_SOP, BODY, DISCARD, META} state_t;
    localparam logic [4:0] MAX_CNT = 5'(MAX_FLITS);
    state_t                   state_q, state_d;
    logic [PKT_AWIDTH-1:0]    pkt_id_q, pkt_id_d;
    logic [4:0]               flit_cnt_q, flit_cnt_d;
    logic                     trunc_q, trunc_d;
    logic                     wr_q, wr_d;
    logic [PKTBUF_AWIDTH-1:0] addr_q, addr_d;
    flit_t                    data_q, data_d;
    logic [31:0]              drop_q, drop_d, orphan_q, orphan_d;
    logic                     len_load;
    logic [4:0]               len_flits;
    logic [5:0]               len_empty;
    logic [15:0]              len;
    logic                     acc;
    flit_t                    in_flit;
    assign in_flit = {in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty};
    assign acc = in_pkt_valid & in_pkt_ready;
    // readies depend on state only; held low while reset is asserted
    assign in_pkt_ready = !rst && (state_q == WAIT_SOP || state_q == BODY || state_q == DISCARD);
    assign emptylist_out_ready = !rst && state_q == FETCH;
    assign meta_valid = !rst && state_q == META;
    assign meta_data = meta_valid ? metadata_t'{pkt_id_q, flit_cnt_q, len, trunc_q ? PKT_DROP : PKT_ETH} : '0;
    assign pkt_buffer_address = addr_q;
    assign pkt_buffer_write = wr_q;
    assign pkt_buffer_writedata = data_q;
    assign drop_cnt = drop_q;
    assign orphan_cnt = orphan_q;
    pkt_len_calc u_len (
        .clk     (clk),
        .rst     (rst),
        .load_i  (len_load),
        .flits_i (len_flits),
        .empty_i (len_empty),
        .len_o   (len)
    );
    // next-state, write staging and counter updates
    always_comb begin
        state_d = state_q;
        pkt_id_d = pkt_id_q;
        flit_cnt_d = flit_cnt_q;
        trunc_d = trunc_q;
        wr_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        drop_d = drop_q;
        orphan_d = orphan_q;
        len_load = 1'b0;
        len_flits = flit_cnt_q;
        len_empty = in_pkt_empty;
        case (state_q)
            FETCH: if (emptylist_out_valid) begin
                pkt_id_d = emptylist_out_data;
                state_d = WAIT_SOP;
            end
            WAIT_SOP: if (acc) begin
                if (!in_pkt_sop) orphan_d = orphan_q + 32'd1;
                else begin
                    wr_d = 1'b1;
                    addr_d = {pkt_id_q, 5'd0};
                    data_d = in_flit;
                    flit_cnt_d = 5'd1;
                    trunc_d = 1'b0;
                    len_load = in_pkt_eop;
                    len_flits = 5'd1;
                    state_d = in_pkt_eop ? META : BODY;
                end
            end
            BODY: if (acc) begin
                if (!in_pkt_eop && flit_cnt_q == MAX_CNT) begin
                    trunc_d = 1'b1;
                    state_d = DISCARD;
                end else begin
                    wr_d = 1'b1;
                    addr_d = {pkt_id_q, flit_cnt_q};
                    data_d = in_flit;
                    flit_cnt_d = flit_cnt_q + 5'd1;
                    len_load = in_pkt_eop;
                    len_flits = flit_cnt_q + 5'd1;
                    state_d = in_pkt_eop ? META : BODY;
                end
            end
            DISCARD: if (acc && in_pkt_eop) begin
                drop_d = drop_q + 32'd1;
                len_load = 1'b1;
                len_empty = 6'd0;
                state_d = META;
            end
            META: if (meta_ready) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end
    // state and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pkt_id_q <= '0;
            flit_cnt_q <= '0;
            trunc_q <= 1'b0;
            wr_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            drop_q <= '0;
            orphan_q <= '0;
        end else begin
            state_q <= state_d;
            pkt_id_q <= pkt_id_d;
            flit_cnt_q <= flit_cnt_d;
            trunc_q <= trunc_d;
            wr_q <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            drop_q <= drop_d;
            orphan_q <= orphan_d;
        end
    end
endmodule

// File: tb/tb_pkt_buffer_writer.sv
// tb_pkt_buffer_writer: directed and randomized packets checked against a packet-level model
module tb_pkt_buffer_writer;
    import my_struct_s::*;
    localparam int MAXF = 24;
    logic clk = 1'b0;
    logic rst;
    logic in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_ready;
    logic [511:0] in_pkt_data;
    logic [5:0] in_pkt_empty;
    logic [PKT_AWIDTH-1:0] emptylist_out_data;
    logic emptylist_out_valid, emptylist_out_ready;
    logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
    logic pkt_buffer_write;
    flit_t pkt_buffer_writedata;
    logic meta_valid, meta_ready;
    metadata_t meta_data;
    logic [31:0] drop_cnt, orphan_cnt;
    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int exp_drop = 0;
    int exp_orph = 0;
    typedef struct {logic [PKTBUF_AWIDTH-1:0] a; flit_t f; int c;} wr_t;
    typedef struct {metadata_t m; int c;} mr_t;
    wr_t wq[$];
    mr_t mq[$];
    flit_t drv[$];
    logic pv = 1'b0;
    metadata_t pm;

    pkt_buffer_writer #(.MAX_FLITS(MAXF)) dut (
        .clk(clk), .rst(rst),
        .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
        .in_pkt_data(in_pkt_data), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
        .emptylist_out_data(emptylist_out_data), .emptylist_out_valid(emptylist_out_valid),
        .emptylist_out_ready(emptylist_out_ready),
        .pkt_buffer_address(pkt_buffer_address), .pkt_buffer_write(pkt_buffer_write),
        .pkt_buffer_writedata(pkt_buffer_writedata),
        .meta_valid(meta_valid), .meta_data(meta_data), .meta_ready(meta_ready),
        .drop_cnt(drop_cnt), .orphan_cnt(orphan_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [599:0] got, input logic [599:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // capture writes and descriptor rises; descriptor must not change while valid
    always @(negedge clk) begin
        if (pkt_buffer_write) wq.push_back('{pkt_buffer_address, pkt_buffer_writedata, cyc});
        if (meta_valid && !pv) mq.push_back('{meta_data, cyc});
        if (meta_valid && pv) chk("meta_stable", 600'(meta_data), 600'(pm));
        pv = meta_valid;
        pm = meta_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_pkt_valid = 1'b0;
        end
    endtask

    task automatic give_id(input int id);
        int t = 0;
        @(negedge clk);
        emptylist_out_valid = 1'b1;
        emptylist_out_data = PKT_AWIDTH'(id);
        while (!emptylist_out_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("pop_timeout", 600'(t < 100), 600'(1));
        @(negedge clk);
        emptylist_out_valid = 1'b0;
    endtask

    task automatic push_flit(input flit_t f, output int acc);
        int t = 0;
        @(negedge clk);
        in_pkt_valid = 1'b1;
        in_pkt_data = f.data;
        in_pkt_sop = f.sop;
        in_pkt_eop = f.eop;
        in_pkt_empty = f.empty;
        while (!in_pkt_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("flit_timeout", 600'(t < 100), 600'(1));
        @(posedge clk);
        #1 acc = cyc;
    endtask

    function automatic flit_t rnd_flit(input bit sop, input bit eop, input logic [5:0] empty);
        flit_t f;
        for (int j = 0; j < 16; j++) f.data[j*32 +: 32] = $urandom;
        f.sop = sop;
        f.eop = eop;
        f.empty = empty;
        return f;
    endfunction

    task automatic send_pkt(input int n, input int e, input bit gaps, output int fa);
        int a;
        flit_t f;
        drv.delete();
        fa = 0;
        for (int i = 0; i < n; i++) begin
            f = rnd_flit((i == 0) || ($urandom_range(7) == 0), i == n - 1, (i == n - 1) ? 6'(e) : 6'($urandom));
            drv.push_back(f);
            push_flit(f, a);
            if (i == 0) fa = a;
            if (gaps && $urandom_range(2) == 0) idle(1 + $urandom_range(1));
        end
        idle(1);
    endtask

    task automatic take_meta();
        int t = 0;
        while (t < 200) begin
            @(negedge clk);
            if (meta_valid && $urandom_range(1) == 1) begin
                meta_ready = 1'b1;
                break;
            end
            t++;
        end
        chk("meta_timeout", 600'(t < 200), 600'(1));
        @(negedge clk);
        meta_ready = 1'b0;
    endtask

    // packet-level expectation: first min(n, MAXF) flits land at id*32+i, then one descriptor
    task automatic check_pkt(input int id, input int n, input int e, input int fa, input bit contig);
        bit tr;
        int nw;
        metadata_t em;
        tr = n > MAXF;
        nw = tr ? MAXF : n;
        em.pktID = PKT_AWIDTH'(id);
        em.flits = 5'(nw);
        em.len = tr ? 16'(MAXF * 64) : 16'((n - 1) * 64 + 64 - e);
        em.pkt_flags = tr ? PKT_DROP : PKT_ETH;
        if (tr) exp_drop++;
        chk("wr_count", 600'(wq.size()), 600'(nw));
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            chk("wr_addr", 600'(wq[i].a), 600'(id * 32 + i));
            chk("wr_data", 600'(wq[i].f), 600'(drv[i]));
            if (contig) chk("wr_cycle", 600'(wq[i].c), 600'(fa + i));
        end
        if (wq.size() > 0) chk("first_wr_lat", 600'(wq[0].c), 600'(fa));
        chk("meta_count", 600'(mq.size()), 600'(1));
        if (mq.size() > 0 && wq.size() > 0) begin
            chk("meta", 600'(mq[0].m), 600'(em));
            chk("meta_vs_data", 600'(tr ? mq[0].c > wq[wq.size()-1].c : mq[0].c == wq[wq.size()-1].c), 600'(1));
        end
        chk("drop_cnt", 600'(drop_cnt), 600'(exp_drop));
        chk("orphan_cnt", 600'(orphan_cnt), 600'(exp_orph));
        wq.delete();
        mq.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 600'(in_pkt_ready), 600'(0));
        chk({tag, "_el_ready"}, 600'(emptylist_out_ready), 600'(0));
        chk({tag, "_write"}, 600'(pkt_buffer_write), 600'(0));
        chk({tag, "_addr"}, 600'(pkt_buffer_address), 600'(0));
        chk({tag, "_wdata"}, 600'(pkt_buffer_writedata), 600'(0));
        chk({tag, "_meta_valid"}, 600'(meta_valid), 600'(0));
        chk({tag, "_meta_data"}, 600'(meta_data), 600'(0));
        chk({tag, "_drop"}, 600'(drop_cnt), 600'(0));
        chk({tag, "_orphan"}, 600'(orphan_cnt), 600'(0));
    endtask

    initial begin
        int fa, n, e, id, r;
        logic rdy;
        flit_t f;
        rst = 1'b1;
        in_pkt_valid = 1'b0;
        in_pkt_sop = 1'b0;
        in_pkt_eop = 1'b0;
        in_pkt_data = '0;
        in_pkt_empty = '0;
        emptylist_out_valid = 1'b0;
        emptylist_out_data = '0;
        meta_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("fetch_el_ready", 600'(emptylist_out_ready), 600'(1));
        chk("fetch_in_ready", 600'(in_pkt_ready), 600'(0));

        // single-flit packet, pktID 7, empty 4
        give_id(7);
        send_pkt(1, 4, 1'b0, fa);
        take_meta();
        check_pkt(7, 1, 4, fa, 1'b1);

        // three-flit packet, pktID 2, last empty 10
        give_id(2);
        send_pkt(3, 10, 1'b0, fa);
        take_meta();
        check_pkt(2, 3, 10, fa, 1'b1);

        // oversize: 30 flits against a 24-flit limit
        give_id(9);
        send_pkt(30, 17, 1'b0, fa);
        take_meta();
        check_pkt(9, 30, 17, fa, 1'b1);

        // emptylist empty for 20 cycles with a flit waiting upstream
        drv.delete();
        f = rnd_flit(1'b1, 1'b1, 6'd20);
        drv.push_back(f);
        @(negedge clk);
        in_pkt_valid = 1'b1;
        in_pkt_data = f.data;
        in_pkt_sop = f.sop;
        in_pkt_eop = f.eop;
        in_pkt_empty = f.empty;
        rdy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            rdy = rdy | in_pkt_ready;
        end
        chk("bp_in_ready", 600'(rdy), 600'(0));
        chk("bp_no_write", 600'(wq.size()), 600'(0));
        emptylist_out_valid = 1'b1;
        emptylist_out_data = PKT_AWIDTH'(5);
        @(negedge clk);
        emptylist_out_valid = 1'b0;
        chk("pop_el_ready_low", 600'(emptylist_out_ready), 600'(0));
        chk("pop_wait_sop", 600'(in_pkt_ready), 600'(1));
        @(posedge clk);
        #1 fa = cyc;
        @(negedge clk);
        in_pkt_valid = 1'b0;
        take_meta();
        check_pkt(5, 1, 20, fa, 1'b1);

        // three orphan flits while waiting for sop, then a normal packet
        give_id(11);
        for (int i = 0; i < 3; i++) push_flit(rnd_flit(1'b0, 1'($urandom), 6'($urandom)), r);
        idle(1);
        exp_orph = 3;
        chk("orphan_cnt3", 600'(orphan_cnt), 600'(3));
        chk("orphan_nowrite", 600'(wq.size()), 600'(0));
        send_pkt(2, 5, 1'b1, fa);
        take_meta();
        check_pkt(11, 2, 5, fa, 1'b0);

        // randomized packets, some oversize
        for (int k = 0; k < 12; k++) begin
            id = $urandom_range(PKT_NUM - 1);
            r = $urandom_range(29);
            n = r < MAXF ? r + 1 : r + 2;
            e = $urandom_range(63);
            give_id(id);
            send_pkt(n, e, k[0], fa);
            take_meta();
            check_pkt(id, n, e, fa, !k[0]);
        end

        // reset in the middle of a packet body
        give_id(3);
        push_flit(rnd_flit(1'b1, 1'b0, 6'd0), r);
        push_flit(rnd_flit(1'b0, 1'b0, 6'd0), r);
        @(negedge clk);
        rst = 1'b1;
        in_pkt_valid = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midbody_rst");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fetch_el_ready", 600'(emptylist_out_ready), 600'(1));
        chk("rst_fetch_in_ready", 600'(in_pkt_ready), 600'(0));
        wq.delete();
        mq.delete();
        exp_drop = 0;
        exp_orph = 0;
        give_id(4);
        send_pkt(4, 33, 1'b0, fa);
        take_meta();
        check_pkt(4, 4, 33, fa, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pkt_buffer_writer.md
# pkt_buffer_writer

Ingress counterpart of the packet-buffer read path: accepts 512-bit Avalon-ST packet flits, allocates a free pktID from the packet emptylist, and writes each flit into the packet buffer at `(pktID << 5) + flit_index`. When a packet completes, it emits one `metadata_t` descriptor downstream to the flow classifier and data mover. Oversize packets are tagged `PKT_DROP` so the data mover returns their pktID to the emptylist.

## Interface
Parameters:
- `MAX_FLITS`, default 24: largest accepted packet in flits. Must be ≤ 31, because `metadata_t.flits` is 5 bits.

Ports (clock and reset first):
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high, on clock `clk`
- `in_pkt_valid / in_pkt_sop / in_pkt_eop`  in  1 each  ingress flit qualifiers
- `in_pkt_data`  in  512  flit payload
- `in_pkt_empty`  in  6  empty bytes in the eop flit
- `in_pkt_ready`  out  1  flit accepted when `valid & ready`
- `emptylist_out_data`  in  PKT_AWIDTH  free pktID
- `emptylist_out_valid`  in  1  emptylist non-empty
- `emptylist_out_ready`  out  1  pop strobe
- `pkt_buffer_address`  out  PKTBUF_AWIDTH  write address
- `pkt_buffer_write`  out  1  write strobe
- `pkt_buffer_writedata`  out  flit_t  `{data, sop, eop, empty}`
- `meta_valid`  out  1  descriptor valid
- `meta_data`  out  metadata_t  `{pktID, flits, len, pkt_flags}`
- `meta_ready`  in  1  descriptor consumed
- `drop_cnt`  out  32  oversize packets seen
- `orphan_cnt`  out  32  flits discarded while waiting for sop

## Operation
- **Reset:** state = FETCH. All outputs are 0 and both counters are 0. Any held pktID is discarded; the read path re-initialises the emptylist after reset.
- **FETCH:**
  - `emptylist_out_ready = 1` and `in_pkt_ready = 0`.
  - On `emptylist_out_valid`, latch `pktID` and go to WAIT_SOP.
- **WAIT_SOP:**
  - `in_pkt_ready = 1`.
  - An accepted flit with sop=0 is discarded and increments `orphan_cnt`.
  - An accepted flit with sop=1 is written to `pktID << 5` and sets `flit_cnt = 1`.
  - If that flit also has eop, go to META; otherwise go to BODY.
- **BODY:**
  - `in_pkt_ready = 1`.
  - Each accepted flit is written to `(pktID << 5) + flit_cnt`, then `flit_cnt++`.
  - On eop, go to META.
  - If a non-eop flit is accepted when `flit_cnt == MAX_FLITS`, do not write it, set the `trunc` flag, and go to DISCARD.
  - A sop flit arriving mid-packet is treated as a payload flit; its sop bit is written through unchanged.
- **DISCARD:**
  - `in_pkt_ready = 1`; flits are dropped, no writes.
  - On eop, increment `drop_cnt` and go to META.
- **META:**
  - `in_pkt_ready = 0`; `meta_valid` is held until `meta_ready`, then go to FETCH.
  - Descriptor fields: `pktID`; `flits = flit_cnt`.
  - `len = (flit_cnt-1)*64 + (64 - last_empty)`, 16-bit unsigned. Use `last_empty = 0` when truncated.
  - `pkt_flags = trunc ? PKT_DROP : PKT_ETH`.
  - `meta_data` is stable while `meta_valid` is high.
- **Emptylist empty:** the block stalls in FETCH with `in_pkt_ready = 0`, applying backpressure upstream. No flits are lost.
- **Counters:** both wrap at 2^32.

## Timing
- Flit accepted in cycle N → `pkt_buffer_write` pulses in N+1, with registered address and data. There is no write backpressure.
- eop accepted in cycle N → `meta_valid` rises in N+1, the same cycle as the final write. The descriptor therefore never precedes its data.
- Emptylist pop: `valid & ready` in FETCH in cycle N → WAIT_SOP in N+1. `emptylist_out_ready` is deasserted in N+1.
- Minimum packet-to-packet gap is 2 cycles (META and FETCH) when `meta_ready` and the emptylist are both ready.
- `in_pkt_ready` is a combinational function of state only, never of `in_pkt_valid`.

## Structure
- `flit_t`, `metadata_t`, `PKT_ETH`, `PKT_DROP`, `PKT_AWIDTH`, `PKTBUF_AWIDTH` and `PKT_NUM` live in the shared `my_struct_s` package.
- The state enum is local to this block.
- One sub-module is natural: `pkt_len_calc`, a registered flit-count/empty → len computation.

## Test plan
- **Single-flit packet:** sop+eop with empty=4 and emptylist supplying pktID=7 → one write at address 224 with data intact; meta `{7, 1, 60, PKT_ETH}` one cycle later.
- **3-flit packet:** pktID=2, last empty=10 → writes at 64, 65, 66 in consecutive cycles; meta len=182, flits=3.
- **Oversize packet** with MAX_FLITS=24: 30-flit packet → 24 writes, 6 flits discarded, meta `{flits=24, len=1536, PKT_DROP}`, `drop_cnt = 1`.
- **Backpressure:** emptylist empty for 20 cycles → `in_pkt_ready = 0` throughout. Then pktID=5 becomes available → WAIT_SOP entered one cycle after the pop; first flit lands at address 160.
- **Orphans and reset:** 3 non-sop flits in WAIT_SOP → `orphan_cnt = 3`, no writes. Separately, assert rst mid-BODY → next cycle all outputs are 0, state is FETCH, and a fresh packet completes normally.
